// File: rtl/hpe_pkg.sv
// Shared types and bit-vector helpers for the high-priority encoder drain.
// Helpers work on MAX_W-bit vectors; callers zero-extend narrower inputs.
package hpe_pkg;

  localparam int MAX_W = 256;

  typedef enum logic {IDLE, DRAIN} hpe_state_t;

  function automatic logic [7:0] msb_index(input logic [MAX_W-1:0] vec, input int width);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width && vec[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_W'(1))) == '0);
  endfunction

  function automatic logic [8:0] popcount(input logic [MAX_W-1:0] vec);
    logic [8:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_W; i++) cnt = cnt + 9'(vec[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/hpe_msb_finder.sv
// Combinational lookup: pending vector -> highest set index and last-bit flag.
module hpe_msb_finder
  import hpe_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] pending_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [MAX_W-1:0] vec_ext;

  assign vec_ext = MAX_W'(pending_i);
  assign idx_o   = IDX_W'(msb_index(vec_ext, WIDTH));
  assign last_o  = is_onehot(vec_ext);

endmodule

// File: rtl/high_priority_encoder_drain.sv
// Captures a request vector and streams out each set index, highest first.
// Optional macro HPE_REMAINING_COUNT_EN adds Remaining_Out = popcount(pending).
module high_priority_encoder_drain
  import hpe_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Data_Valid_In,
  output logic             Data_Ready_Out,
  output logic [IDX_W-1:0] Encoded_Value_Out,
  output logic             Encoded_Valid_Out,
  output logic             Encoded_Last_Out,
  input  logic             Encoded_Ready_In,
`ifdef HPE_REMAINING_COUNT_EN
  output logic [IDX_W:0]   Remaining_Out,
`endif
  output logic             Busy_Out
);

  hpe_state_t       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             out_en_q;
  logic [IDX_W-1:0] msb_idx;
  logic             msb_last;
  logic             xfer;

  hpe_msb_finder #(.WIDTH(WIDTH)) u_msb_finder (
    .pending_i (pending_q),
    .idx_o     (msb_idx),
    .last_o    (msb_last)
  );

  assign xfer = (state_q == DRAIN) && Encoded_Ready_In;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        // Capture only while Data_Ready_Out is shown, i.e. not on the release edge.
        if (Data_Valid_In && out_en_q) begin
          pending_d = Data_In;
          if (Data_In != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          pending_d[msb_idx] = 1'b0;
          if (msb_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_en_q  <= 1'b1;
    end
  end

  // Outputs derive from registers only; out_en_q holds Data_Ready_Out low through reset.
  assign Data_Ready_Out    = out_en_q && (state_q == IDLE);
  assign Busy_Out          = (state_q == DRAIN);
  assign Encoded_Valid_Out = (state_q == DRAIN);
  assign Encoded_Value_Out = msb_idx;
  assign Encoded_Last_Out  = msb_last;

`ifdef HPE_REMAINING_COUNT_EN
  assign Remaining_Out = (IDX_W+1)'(popcount(MAX_W'(pending_q)));
`endif

endmodule

// File: tb/tb_high_priority_encoder_drain.sv
// Self-checking bench for high_priority_encoder_drain (WIDTH=8) against a queue model.
// Define HPE_REMAINING_COUNT_EN to also check Remaining_Out.
module tb_high_priority_encoder_drain;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             data_ready;
  logic [IDX_W-1:0] enc_value;
  logic             enc_valid;
  logic             enc_last;
  logic             enc_ready;
  logic             busy;
`ifdef HPE_REMAINING_COUNT_EN
  logic [IDX_W:0]   remaining;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  high_priority_encoder_drain #(.WIDTH(WIDTH)) dut (
    .Clock_In          (clk),
    .Reset_In          (rst_n),
    .Data_In           (data),
    .Data_Valid_In     (data_valid),
    .Data_Ready_Out    (data_ready),
    .Encoded_Value_Out (enc_value),
    .Encoded_Valid_Out (enc_valid),
    .Encoded_Last_Out  (enc_last),
    .Encoded_Ready_In  (enc_ready),
`ifdef HPE_REMAINING_COUNT_EN
    .Remaining_Out     (remaining),
`endif
    .Busy_Out          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: the set indices of the vector, listed from highest to lowest.
  task automatic load_model(input logic [WIDTH-1:0] vec);
    exp_q.delete();
    for (int i = WIDTH - 1; i >= 0; i--) if (vec[i]) exp_q.push_back(i);
  endtask

  task automatic expect_state(input string tag, input bit drain, input bit rdy_exp);
    check({tag, ".valid"}, 32'(enc_valid), 32'(drain));
    check({tag, ".busy"}, 32'(busy), 32'(drain));
    check({tag, ".ready"}, 32'(data_ready), 32'(rdy_exp));
    if (drain) begin
      check({tag, ".value"}, 32'(enc_value), 32'(exp_q[0]));
      check({tag, ".last"}, 32'(enc_last), 32'(exp_q.size() == 1));
    end
`ifdef HPE_REMAINING_COUNT_EN
    check({tag, ".remaining"}, 32'(remaining), 32'(exp_q.size()));
`endif
  endtask

  task automatic expect_reset_outputs(input string tag);
    expect_state(tag, 1'b0, 1'b0);
    check({tag, ".value0"}, 32'(enc_value), 32'd0);
    check({tag, ".last0"}, 32'(enc_last), 32'd0);
  endtask

  // Capture vec, then drain it; ready stalls for 'stall' cycles, then is random or held high.
  task automatic run_vec(input logic [WIDTH-1:0] vec, input int stall, input bit rand_rdy,
                         input bit noise_en, input logic [WIDTH-1:0] noise_data);
    int n;
    bit rdy;
    data       = vec;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data       = '0;
    load_model(vec);
    n = 0;
    while (exp_q.size() > 0) begin
      expect_state("drain", 1'b1, 1'b0);
      if (n < stall) rdy = 1'b0;
      else           rdy = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      enc_ready = rdy;
      if (noise_en) begin
        data_valid = 1'b1;
        data       = noise_data;
      end
      step();
      if (rdy) void'(exp_q.pop_front());
      n++;
    end
    data_valid = 1'b0;
    data       = '0;
    enc_ready  = 1'b0;
    expect_state("idle_after", 1'b0, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    enc_ready  = 1'b0;

    // 1. Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      step();
      expect_reset_outputs("reset_hold");
    end
    rst_n = 1'b1;
    step();
    expect_state("reset_release", 1'b0, 1'b1);

    // 2. Mixed vector, ready held high: 7,5,2,1.
    run_vec(8'b1010_0110, 0, 1'b0, 1'b0, '0);

    // 3. All-zero vector is dropped.
    run_vec(8'h00, 0, 1'b0, 1'b0, '0);
    step();
    expect_state("zero_stays_idle", 1'b0, 1'b1);

    // 4. Stall four cycles on 8'h81, then drain.
    run_vec(8'h81, 4, 1'b0, 1'b0, '0);

    // 5. Reset in the middle of draining 8'hFF.
    data       = 8'hFF;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data       = '0;
    load_model(8'hFF);
    for (int i = 0; i < 3; i++) begin
      expect_state("ff_drain", 1'b1, 1'b0);
      enc_ready = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    enc_ready = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    step();
    expect_reset_outputs("mid_reset");
    rst_n = 1'b1;
    step();
    expect_state("mid_reset_release", 1'b0, 1'b1);
    run_vec(8'h10, 0, 1'b0, 1'b0, '0);

    // 6. Input activity during DRAIN is ignored.
    run_vec(8'h0F, 0, 1'b0, 1'b1, 8'hFF);

    // Randomized vectors, stalls and input noise.
    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] vec;
      vec = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
      run_vec(vec, $urandom_range(2), 1'b1, 1'($urandom_range(1)), WIDTH'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
